tlul_addr_router: RTL and testbench
===================================

# tlul_addr_router

Parametrised TL-UL 1:N address router, successor to the fixed peripheral crossbar. It has a programmable decode table, outstanding-transaction tracking and a built-in error responder for unmapped addresses. It sits between one host port (core LSU or debug master) and N device ports. It guarantees in-order responses by stalling requests that would switch target while earlier transactions are still pending.

## Interface
Parameters:
- `N`, 11, number of device ports (1..16).
- `AW`, 32, address width compared by the decoder.
- `MaxOutstanding`, 4, maximum in-flight requests (1..15); sets counter width `OW = $clog2(MaxOutstanding+1)`.
- `AddrBase`, all-zero `[N][AW]`, base address per device.
- `AddrMask`, all-zero `[N][AW]`, don't-care bits per device. A hit is `(a_address & ~AddrMask[i]) == AddrBase[i]`.

Ports:
- `clk_i`, in, 1, clock.
- `rst_ni`, in, 1. Reset is synchronous and active-low: sampled on the rising edge of `clk_i`.
- `tl_h_i`, in, `tl_h2d_t`, host request channel.
- `tl_h_o`, out, `tl_d2h_t`, host response channel.
- `tl_d_o`, out, `tl_h2d_t [N]`, device request channels.
- `tl_d_i`, in, `tl_d2h_t [N]`, device response channels.
- `outstanding_o`, out, `OW`, current in-flight count (debug/perf).
- `err_cnt_o`, out, 8, count of decode errors. Saturates at 255.

## Operation
- Decode is combinational on `tl_h_i.a_address`. Priority goes to the lowest index hit. No hit selects target `N` (the error responder).
- Request path is zero-latency:
  - `tl_d_o[sel]` mirrors `tl_h_i`, with `a_valid` gated by `allow`.
  - All other `tl_d_o[j].a_valid` = 0.
  - `d_ready` is broadcast only to `tl_d_o[tgt_q]`.
- State:
  - `tgt_q` (target of pending transactions, 0..N).
  - `cnt_q` (0..MaxOutstanding).
  - Error responder registers: `err_pend_q`, `err_opcode_q`, `err_size_q`, `err_source_q`.
- `allow = (cnt_q == 0) | ((sel == tgt_q) & (cnt_q < MaxOutstanding))`.
- `tl_h_o.a_ready = allow & (sel < N ? tl_d_i[sel].a_ready : ~err_pend_q)`.
- On request handshake (`a_valid & a_ready`): `tgt_q <= sel` and `cnt_q` increments.
- On response handshake (`tl_h_o.d_valid & tl_h_i.d_ready`): `cnt_q` decrements. If both handshakes occur in the same cycle, `cnt_q` is unchanged.
- The response mux selects `tl_d_i[tgt_q]` when `tgt_q < N`, otherwise the error responder. A `d_valid` from any non-target device is ignored and its `d_ready` is 0.
- Error responder:
  - Accepts one request when `!err_pend_q`, then sets `err_pend_q`.
  - Response fields:
    - `d_opcode` = AccessAckData (1) for Get (4), otherwise AccessAck (0).
    - `d_error` = 1.
    - `d_data` = all-ones.
    - `d_size` and `d_source` echo the captured request.
  - Holds `d_valid` until `d_ready`, then clears `err_pend_q`.
  - `err_cnt_o` increments on each accepted errored request.
- The router never reorders responses and adds no buffering of data.

## Timing
- Reset (`rst_ni` low at an edge) forces the following, and they hold while `rst_ni` is low:
  - `cnt_q`=0, `tgt_q`=N, `err_pend_q`=0, `err_cnt_o`=0.
  - `tl_h_o.a_ready`=0, `tl_h_o.d_valid`=0.
  - All `tl_d_o[j].a_valid`=0 and `d_ready`=0.
- Reset mid-transaction discards all tracking. Device responses arriving after reset release are ignored because `cnt_q`=0 and `tgt_q`=N.
- Device access latency equals device latency; the router adds 0 cycles.
- Error response: `d_valid` is asserted the cycle after the request handshake. Minimum 2 cycles per errored transaction, so back-to-back errored requests stall 1 cycle.
- Target switch: a request to a new target waits until `cnt_q` returns to 0. It may be accepted in the same cycle as the last response handshake, because `allow` uses the post-decrement rule `cnt_q==1 & rsp_hs`.
- Full: at `cnt_q == MaxOutstanding`, `a_ready`=0 unless a response handshake occurs that cycle (same bypass rule).
- `a_valid` may be asserted while `a_ready` is low. The host must hold the request stable, per TL-UL rules.

## Test plan
- Table N=3 (bases 0x1000/0x2000/0x3000, mask 0xFFF). Get to 0x2004 -> only `tl_d_o[1].a_valid`=1. The response from device 1 is passed unchanged with 0 added cycles.
- Put to unmapped 0x9000 -> one cycle later `d_valid`=1, `d_opcode`=0, `d_error`=1. Get to unmapped -> `d_opcode`=1, `d_data`=0xFFFFFFFF. `err_cnt_o` reaches 2.
- MaxOutstanding=2, device 0 withholds responses, host issues 3 Gets to device 0 -> third `a_ready`=0 until the first `d_ready` handshake. It is accepted in that same cycle and `outstanding_o` stays at 2.
- Request to device 0, then immediate request to device 2 -> device 2 request stalled until the device 0 response handshake. Response order is preserved.
- Overlapping table entries 0 and 1 both hit -> device 0 selected.
- Assert `rst_ni`=0 with `cnt_q`=2, then release; the stale device response arrives afterward -> `tl_h_o.d_valid` stays 0, `outstanding_o`=0, and a new request to any device is accepted immediately.

Source files
------------

// File: rtl/tlul_addr_router.sv
// TL-UL 1:N address router: programmable decode table, in-order outstanding tracking
// and a built-in error responder for unmapped addresses.

package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  localparam logic [2:0] OpGet            = 3'd4;
  localparam logic [2:0] OpAccessAck      = 3'd0;
  localparam logic [2:0] OpAccessAckData  = 3'd1;

endpackage

module tlul_addr_router
  import tlul_pkg::*;
#(
  parameter int unsigned N              = 11,
  parameter int unsigned AW             = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter logic [N-1:0][AW-1:0] AddrBase = '0,
  parameter logic [N-1:0][AW-1:0] AddrMask = '0,
  localparam int unsigned OW = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  tl_h2d_t             tl_h_i,
  output tl_d2h_t             tl_h_o,
  output tl_h2d_t [N-1:0]     tl_d_o,
  input  tl_d2h_t [N-1:0]     tl_d_i,
  output logic [OW-1:0]       outstanding_o,
  output logic [7:0]          err_cnt_o
);

  localparam int unsigned TW = $clog2(N + 1);
  localparam logic [TW-1:0] ErrTgt = TW'(N);

  logic [TW-1:0] sel;
  logic [TW-1:0] tgt_q;
  logic [OW-1:0] cnt_q;
  logic          err_pend_q;
  logic [2:0]    err_opcode_q;
  logic [1:0]    err_size_q;
  logic [7:0]    err_source_q;
  logic [7:0]    err_cnt_q;

  logic          cnt_nz;
  logic          allow;
  logic          dev_a_ready;
  logic          a_ready;
  logic          rsp_valid;
  logic          req_hs;
  logic          rsp_hs;
  tl_d2h_t       rsp_sel;

  // Address decode: lowest matching index wins, no match routes to the error responder.
  always_comb begin
    sel = ErrTgt;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if ((tl_h_i.a_address[AW-1:0] & ~AddrMask[i]) == AddrBase[i]) begin
        sel = TW'(i);
      end
    end
  end

  // Response source: the pending target device, or the local error responder.
  always_comb begin
    rsp_sel          = '0;
    rsp_sel.d_valid  = err_pend_q;
    rsp_sel.d_opcode = (err_opcode_q == OpGet) ? OpAccessAckData : OpAccessAck;
    rsp_sel.d_size   = err_size_q;
    rsp_sel.d_source = err_source_q;
    rsp_sel.d_data   = '1;
    rsp_sel.d_error  = 1'b1;
    dev_a_ready      = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (TW'(j) == tgt_q) begin
        rsp_sel = tl_d_i[j];
      end
      if (TW'(j) == sel) begin
        dev_a_ready = tl_d_i[j].a_ready;
      end
    end
  end

  assign cnt_nz    = (cnt_q != '0);
  assign rsp_valid = rst_ni & cnt_nz & rsp_sel.d_valid;
  assign rsp_hs    = rsp_valid & tl_h_i.d_ready;

  // A response retiring this cycle frees a slot (or the last one) for the new request.
  assign allow = (cnt_q == '0)
               | ((cnt_q == OW'(1)) & rsp_hs)
               | ((sel == tgt_q) & ((cnt_q < OW'(MaxOutstanding)) | rsp_hs));

  assign a_ready = rst_ni & allow & ((sel < ErrTgt) ? dev_a_ready : ~err_pend_q);
  assign req_hs  = tl_h_i.a_valid & a_ready;

  always_comb begin
    tl_h_o          = rsp_sel;
    tl_h_o.d_valid  = rsp_valid;
    tl_h_o.a_ready  = a_ready;
  end

  // Request fan-out: only the decoded device sees a_valid; d_ready only to the pending target.
  always_comb begin
    for (int unsigned j = 0; j < N; j++) begin
      tl_d_o[j]         = tl_h_i;
      tl_d_o[j].a_valid = rst_ni & allow & tl_h_i.a_valid & (sel == TW'(j));
      tl_d_o[j].d_ready = rst_ni & cnt_nz & tl_h_i.d_ready & (tgt_q == TW'(j));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tgt_q        <= ErrTgt;
      cnt_q        <= '0;
      err_pend_q   <= 1'b0;
      err_opcode_q <= '0;
      err_size_q   <= '0;
      err_source_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      if (req_hs) begin
        tgt_q <= sel;
      end
      case ({req_hs, rsp_hs})
        2'b10:   cnt_q <= cnt_q + OW'(1);
        2'b01:   cnt_q <= cnt_q - OW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (req_hs && (sel == ErrTgt)) begin
        err_pend_q   <= 1'b1;
        err_opcode_q <= tl_h_i.a_opcode;
        err_size_q   <= tl_h_i.a_size;
        err_source_q <= tl_h_i.a_source;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end else if (rsp_hs && (tgt_q == ErrTgt)) begin
        err_pend_q <= 1'b0;
      end
    end
  end

  assign outstanding_o = cnt_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_tlul_addr_router.sv
// Directed self-checking bench for tlul_addr_router (3-device table, 2 outstanding).

module tb_tlul_addr_router;
  import tlul_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  tl_h2d_t       h_req;
  tl_d2h_t       h_rsp;
  tl_h2d_t [2:0] d_req;
  tl_d2h_t [2:0] d_rsp;
  logic [1:0]    outstanding;
  logic [7:0]    err_cnt;

  tl_h2d_t       o_h_req;
  tl_d2h_t       o_h_rsp;
  tl_h2d_t [1:0] o_d_req;
  tl_d2h_t [1:0] o_d_rsp;
  logic [2:0]    o_outstanding;
  logic [7:0]    o_err_cnt;

  tlul_addr_router #(
    .N(3), .AW(32), .MaxOutstanding(2),
    .AddrBase({32'h0000_3000, 32'h0000_2000, 32'h0000_1000}),
    .AddrMask({32'h0000_0FFF, 32'h0000_0FFF, 32'h0000_0FFF})
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .tl_h_i(h_req), .tl_h_o(h_rsp),
    .tl_d_o(d_req), .tl_d_i(d_rsp), .outstanding_o(outstanding), .err_cnt_o(err_cnt)
  );

  // Entry 1 (0x0000/0xFFFF) overlaps entry 0 (0x1000/0x0FFF).
  tlul_addr_router #(
    .N(2), .AW(32), .MaxOutstanding(4),
    .AddrBase({32'h0000_0000, 32'h0000_1000}),
    .AddrMask({32'h0000_FFFF, 32'h0000_0FFF})
  ) u_ovl (
    .clk_i(clk), .rst_ni(rst_n), .tl_h_i(o_h_req), .tl_h_o(o_h_rsp),
    .tl_d_o(o_d_req), .tl_d_i(o_d_rsp), .outstanding_o(o_outstanding), .err_cnt_o(o_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic [2:0] op, input logic [31:0] addr,
                         input logic [1:0] size, input logic [7:0] src);
    h_req.a_valid   = 1'b1;
    h_req.a_opcode  = op;
    h_req.a_address = addr;
    h_req.a_size    = size;
    h_req.a_source  = src;
  endtask

  task automatic dev_resp(input int idx, input logic v, input logic [31:0] data,
                          input logic [7:0] src);
    d_rsp[idx].d_valid  = v;
    d_rsp[idx].d_opcode = 3'd1;
    d_rsp[idx].d_size   = 2'd2;
    d_rsp[idx].d_source = src;
    d_rsp[idx].d_data   = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(3'd4, 32'h1000, 2'd2, 8'd0);
    dev_resp(0, 1'b1, 32'h1234, 8'd0);
    h_req.d_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (h_rsp.a_ready !== 1'b0) begin failures++; $display("FAIL reset_a_ready got=%0b exp=0", h_rsp.a_ready); end
    checks++; if (h_rsp.d_valid !== 1'b0) begin failures++; $display("FAIL reset_d_valid got=%0b exp=0", h_rsp.d_valid); end
    checks++; if (d_req[0].a_valid !== 1'b0 || d_req[0].d_ready !== 1'b0) begin failures++; $display("FAIL reset_dev0 got=%0b%0b exp=00", d_req[0].a_valid, d_req[0].d_ready); end
    checks++; if (outstanding !== 2'd0 || err_cnt !== 8'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", outstanding, err_cnt); end
    h_req.a_valid = 1'b0;
    h_req.d_ready = 1'b0;
    dev_resp(0, 1'b0, 32'h0, 8'd0);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_decode();
    set_req(3'd4, 32'h2004, 2'd2, 8'd3);
    h_req.d_ready = 1'b1;
    #1;
    checks++; if ({d_req[2].a_valid, d_req[1].a_valid, d_req[0].a_valid} !== 3'b010) begin failures++; $display("FAIL decode_sel got=%b exp=010", {d_req[2].a_valid, d_req[1].a_valid, d_req[0].a_valid}); end
    checks++; if (h_rsp.a_ready !== 1'b1 || d_req[1].a_address !== 32'h2004) begin failures++; $display("FAIL decode_fwd got=%0b/%0h exp=1/2004", h_rsp.a_ready, d_req[1].a_address); end
    cyc();
    h_req.a_valid = 1'b0;
    dev_resp(1, 1'b1, 32'hCAFE_0001, 8'd3);
    #1;
    checks++; if (h_rsp.d_valid !== 1'b1 || h_rsp.d_data !== 32'hCAFE_0001 || h_rsp.d_source !== 8'd3) begin failures++; $display("FAIL decode_rsp got=%0b/%0h/%0d exp=1/cafe0001/3", h_rsp.d_valid, h_rsp.d_data, h_rsp.d_source); end
    checks++; if (d_req[1].d_ready !== 1'b1 || d_req[0].d_ready !== 1'b0 || outstanding !== 2'd1) begin failures++; $display("FAIL decode_dready got=%0b%0b/%0d exp=10/1", d_req[1].d_ready, d_req[0].d_ready, outstanding); end
    cyc();
    dev_resp(1, 1'b0, 32'h0, 8'd0);
    h_req.d_ready = 1'b0;
    #1;
    checks++; if (outstanding !== 2'd0) begin failures++; $display("FAIL decode_drain got=%0d exp=0", outstanding); end
  endtask

  task automatic test_error();
    set_req(3'd0, 32'h9000, 2'd2, 8'd7);
    #1;
    checks++; if (h_rsp.a_ready !== 1'b1 || {d_req[2].a_valid, d_req[1].a_valid, d_req[0].a_valid} !== 3'b000) begin failures++; $display("FAIL err_put_accept got=%0b/%b exp=1/000", h_rsp.a_ready, {d_req[2].a_valid, d_req[1].a_valid, d_req[0].a_valid}); end
    cyc();
    h_req.a_valid = 1'b0;
    #1;
    checks++; if (h_rsp.d_valid !== 1'b1 || h_rsp.d_opcode !== 3'd0 || h_rsp.d_error !== 1'b1 || h_rsp.d_source !== 8'd7) begin failures++; $display("FAIL err_put_rsp got=%0b/%0d/%0b/%0d exp=1/0/1/7", h_rsp.d_valid, h_rsp.d_opcode, h_rsp.d_error, h_rsp.d_source); end
    checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL err_cnt1 got=%0d exp=1", err_cnt); end
    h_req.d_ready = 1'b1;
    cyc();
    h_req.d_ready = 1'b0;
    set_req(3'd4, 32'hA000, 2'd1, 8'd9);
    #1;
    checks++; if (h_rsp.a_ready !== 1'b1 || h_rsp.d_valid !== 1'b0) begin failures++; $display("FAIL err_get_accept got=%0b/%0b exp=1/0", h_rsp.a_ready, h_rsp.d_valid); end
    cyc();
    set_req(3'd4, 32'hB000, 2'd2, 8'd10);
    h_req.d_ready = 1'b1;
    #1;
    checks++; if (h_rsp.d_opcode !== 3'd1 || h_rsp.d_data !== 32'hFFFF_FFFF || h_rsp.d_size !== 2'd1 || h_rsp.d_source !== 8'd9) begin failures++; $display("FAIL err_get_rsp got=%0d/%0h/%0d/%0d exp=1/ffffffff/1/9", h_rsp.d_opcode, h_rsp.d_data, h_rsp.d_size, h_rsp.d_source); end
    checks++; if (h_rsp.a_ready !== 1'b0 || err_cnt !== 8'd2) begin failures++; $display("FAIL err_stall got=%0b/%0d exp=0/2", h_rsp.a_ready, err_cnt); end
    cyc();
    h_req.a_valid = 1'b0;
    h_req.d_ready = 1'b0;
    #1;
    checks++; if (outstanding !== 2'd0 || err_cnt !== 8'd2 || h_rsp.d_valid !== 1'b0) begin failures++; $display("FAIL err_done got=%0d/%0d/%0b exp=0/2/0", outstanding, err_cnt, h_rsp.d_valid); end
  endtask

  task automatic test_full();
    set_req(3'd4, 32'h1000, 2'd2, 8'd1);
    #1;
    checks++; if (h_rsp.a_ready !== 1'b1) begin failures++; $display("FAIL full_first got=%0b exp=1", h_rsp.a_ready); end
    cyc();
    #1;
    checks++; if (h_rsp.a_ready !== 1'b1 || outstanding !== 2'd1) begin failures++; $display("FAIL full_second got=%0b/%0d exp=1/1", h_rsp.a_ready, outstanding); end
    cyc();
    #1;
    checks++; if (h_rsp.a_ready !== 1'b0 || d_req[0].a_valid !== 1'b0 || outstanding !== 2'd2) begin failures++; $display("FAIL full_stall got=%0b/%0b/%0d exp=0/0/2", h_rsp.a_ready, d_req[0].a_valid, outstanding); end
    cyc();
    dev_resp(0, 1'b1, 32'h0000_0011, 8'd1);
    h_req.d_ready = 1'b1;
    #1;
    checks++; if (h_rsp.a_ready !== 1'b1 || d_req[0].a_valid !== 1'b1 || h_rsp.d_valid !== 1'b1) begin failures++; $display("FAIL full_bypass got=%0b/%0b/%0b exp=1/1/1", h_rsp.a_ready, d_req[0].a_valid, h_rsp.d_valid); end
    cyc();
    h_req.a_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 2'd2) begin failures++; $display("FAIL full_hold got=%0d exp=2", outstanding); end
    cyc();
    cyc();
    dev_resp(0, 1'b0, 32'h0, 8'd0);
    h_req.d_ready = 1'b0;
    #1;
    checks++; if (outstanding !== 2'd0) begin failures++; $display("FAIL full_drain got=%0d exp=0", outstanding); end
  endtask

  task automatic test_back_to_back();
    set_req(3'd4, 32'h1000, 2'd2, 8'd2);
    cyc();
    set_req(3'd4, 32'h3000, 2'd2, 8'd4);
    dev_resp(2, 1'b1, 32'h0000_0BAD, 8'd4);
    #1;
    checks++; if (h_rsp.a_ready !== 1'b0 || d_req[2].a_valid !== 1'b0) begin failures++; $display("FAIL switch_stall got=%0b/%0b exp=0/0", h_rsp.a_ready, d_req[2].a_valid); end
    checks++; if (h_rsp.d_valid !== 1'b0 || d_req[2].d_ready !== 1'b0) begin failures++; $display("FAIL switch_stray got=%0b/%0b exp=0/0", h_rsp.d_valid, d_req[2].d_ready); end
    cyc();
    dev_resp(2, 1'b0, 32'h0, 8'd0);
    dev_resp(0, 1'b1, 32'h0000_00A0, 8'd2);
    h_req.d_ready = 1'b1;
    #1;
    checks++; if (h_rsp.a_ready !== 1'b1 || d_req[2].a_valid !== 1'b1 || h_rsp.d_data !== 32'h0000_00A0) begin failures++; $display("FAIL switch_go got=%0b/%0b/%0h exp=1/1/a0", h_rsp.a_ready, d_req[2].a_valid, h_rsp.d_data); end
    cyc();
    h_req.a_valid = 1'b0;
    dev_resp(0, 1'b0, 32'h0, 8'd0);
    dev_resp(2, 1'b1, 32'h0000_00C2, 8'd4);
    #1;
    checks++; if (h_rsp.d_data !== 32'h0000_00C2 || h_rsp.d_source !== 8'd4 || outstanding !== 2'd1) begin failures++; $display("FAIL switch_order got=%0h/%0d/%0d exp=c2/4/1", h_rsp.d_data, h_rsp.d_source, outstanding); end
    cyc();
    dev_resp(2, 1'b0, 32'h0, 8'd0);
    h_req.d_ready = 1'b0;
  endtask

  task automatic test_overlap();
    o_h_req.a_valid   = 1'b1;
    o_h_req.a_opcode  = 3'd4;
    o_h_req.a_address = 32'h1004;
    #1;
    checks++; if ({o_d_req[1].a_valid, o_d_req[0].a_valid} !== 2'b01) begin failures++; $display("FAIL overlap_low got=%b exp=01", {o_d_req[1].a_valid, o_d_req[0].a_valid}); end
    o_h_req.a_address = 32'h2004;
    #1;
    checks++; if ({o_d_req[1].a_valid, o_d_req[0].a_valid} !== 2'b10) begin failures++; $display("FAIL overlap_only1 got=%b exp=10", {o_d_req[1].a_valid, o_d_req[0].a_valid}); end
    o_h_req.a_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    set_req(3'd4, 32'h2000, 2'd2, 8'd6);
    cyc();
    cyc();
    h_req.a_valid = 1'b0;
    #1;
    checks++; if (outstanding !== 2'd2) begin failures++; $display("FAIL mid_pending got=%0d exp=2", outstanding); end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    dev_resp(1, 1'b1, 32'h0000_0005, 8'd6);
    h_req.d_ready = 1'b1;
    #1;
    checks++; if (h_rsp.d_valid !== 1'b0 || outstanding !== 2'd0 || d_req[1].d_ready !== 1'b0) begin failures++; $display("FAIL mid_stale got=%0b/%0d/%0b exp=0/0/0", h_rsp.d_valid, outstanding, d_req[1].d_ready); end
    set_req(3'd4, 32'h3000, 2'd2, 8'd8);
    #1;
    checks++; if (h_rsp.a_ready !== 1'b1 || d_req[2].a_valid !== 1'b1) begin failures++; $display("FAIL mid_new got=%0b/%0b exp=1/1", h_rsp.a_ready, d_req[2].a_valid); end
    cyc();
    h_req.a_valid = 1'b0;
    dev_resp(1, 1'b0, 32'h0, 8'd0);
    h_req.d_ready = 1'b0;
    #1;
    checks++; if (outstanding !== 2'd1) begin failures++; $display("FAIL mid_count got=%0d exp=1", outstanding); end
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    checks   = 0;
    failures = 0;
    h_req    = '0;
    o_h_req  = '0;
    d_rsp    = '0;
    o_d_rsp  = '0;
    for (int i = 0; i < 3; i++) d_rsp[i].a_ready = 1'b1;
    for (int i = 0; i < 2; i++) o_d_rsp[i].a_ready = 1'b1;
    test_reset();
    test_decode();
    cyc();
    test_error();
    cyc();
    test_full();
    cyc();
    test_back_to_back();
    test_overlap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
